// File: rtl/cordic_vector.sv
// cordic_vector: iterative CORDIC in vectoring mode. Converts a signed
// cartesian vector (x_in, y_in) into an unsigned phase (65536 LSB per turn)
// and a gain-compensated magnitude, one micro-rotation per clock.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   x_in, y_in           signed 16-bit input vector, sampled on accept
//   in_valid, in_ready   input handshake; in_ready is high only when idle
//   phase, mag           registered results, held until taken
//   out_valid, out_ready output handshake
module cordic_vector #(
  parameter int unsigned ITER = 12,
  parameter int unsigned KN   = 19898
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic        [15:0] phase,
  output logic        [15:0] mag,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned DW = 16;
  localparam int unsigned XW = 18;
  localparam int unsigned IW = $clog2(ITER + 1);
  localparam int unsigned PW = 36;
  localparam int unsigned SW = PW - 15;
  localparam logic signed [PW-1:0] KN_S = PW'(KN);

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_SCALE, ST_DONE} state_e;

  state_e               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic        [DW-1:0] z_q, z_d;
  logic        [IW-1:0] i_q, i_d;
  logic                 zero_q, zero_d;
  logic        [DW-1:0] phase_q, phase_d, mag_q, mag_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;

  logic signed [XW-1:0] x_sh_c, y_sh_c;
  logic        [DW-1:0] atan_c;
  logic signed [PW-1:0] prod_c;
  logic signed [SW-1:0] scaled_c;
  logic        [DW-1:0] mag_sat_c;

  // atan(2^-i) in phase LSBs
  function automatic logic [DW-1:0] atan_lut(input logic [IW-1:0] idx);
    case (idx)
      IW'(0):  atan_lut = 16'd8192;
      IW'(1):  atan_lut = 16'd4836;
      IW'(2):  atan_lut = 16'd2555;
      IW'(3):  atan_lut = 16'd1297;
      IW'(4):  atan_lut = 16'd651;
      IW'(5):  atan_lut = 16'd326;
      IW'(6):  atan_lut = 16'd163;
      IW'(7):  atan_lut = 16'd81;
      IW'(8):  atan_lut = 16'd41;
      IW'(9):  atan_lut = 16'd20;
      IW'(10): atan_lut = 16'd10;
      IW'(11): atan_lut = 16'd5;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  // Micro-rotation operands and gain-compensated, saturated magnitude
  always_comb begin
    x_sh_c   = x_q >>> i_q;
    y_sh_c   = y_q >>> i_q;
    atan_c   = atan_lut(i_q);
    prod_c   = PW'(x_q) * KN_S;
    scaled_c = SW'(prod_c >>> 15);
    if (scaled_c[SW-1]) begin
      mag_sat_c = '0;
    end else if (|scaled_c[SW-2:DW]) begin
      mag_sat_c = '1;
    end else begin
      mag_sat_c = scaled_c[DW-1:0];
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    zero_d      = zero_q;
    phase_d     = phase_q;
    mag_d       = mag_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Fold left half-plane into the right so the iterations converge
          if (x_in[15]) begin
            x_d = -XW'(x_in);
            y_d = -XW'(y_in);
            z_d = 16'h8000;
          end else begin
            x_d = XW'(x_in);
            y_d = XW'(y_in);
            z_d = '0;
          end
          zero_d     = (x_in == 16'sd0) && (y_in == 16'sd0);
          i_d        = '0;
          in_ready_d = 1'b0;
          state_d    = ST_ITER;
        end
      end
      ST_ITER: begin
        if (!y_q[XW-1]) begin
          x_d = x_q + y_sh_c;
          y_d = y_q - x_sh_c;
          z_d = z_q + atan_c;
        end else begin
          x_d = x_q - y_sh_c;
          y_d = y_q + x_sh_c;
          z_d = z_q - atan_c;
        end
        i_d = i_q + IW'(1);
        if (i_q == IW'(ITER - 1)) begin
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        // A zero vector has no defined angle; report all-zero instead
        phase_d     = zero_q ? '0 : z_q;
        mag_d       = zero_q ? '0 : mag_sat_c;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      zero_q      <= 1'b0;
      phase_q     <= '0;
      mag_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      i_q         <= i_d;
      zero_q      <= zero_d;
      phase_q     <= phase_d;
      mag_q       <= mag_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign phase     = phase_q;
  assign mag       = mag_q;
  assign out_valid = out_valid_q;

endmodule
